// File: rtl/key_pkg.sv
// ---------------------------------------------------------------------------
// key_pkg
// Shared definitions for the key_scan_ctrl debounce scheduler:
//   - key_fsm_e   : scheduler FSM states (IDLE, DEBOUNCE, COMMIT)
//   - KEY_CNT_W   : default debounce counter width
//   - KEY_CNT_MAX : default last counter value (20 ms at 50 MHz)
//   - rr_pick     : round-robin search over a request vector
// ---------------------------------------------------------------------------
package key_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        DEBOUNCE = 2'd1,
        COMMIT   = 2'd2
    } key_fsm_e;

    localparam int unsigned KEY_MAX_NUM   = 16;
    localparam int unsigned KEY_MAX_IDX_W = 4;

    localparam int unsigned KEY_CNT_W     = 20;
    localparam logic [19:0] KEY_CNT_MAX   = 20'd999_999;

    // Returns the first set bit of req[num-1:0], searching upward from
    // last+1 and wrapping. Returns last when nothing is requested.
    function automatic int unsigned rr_pick(
        input logic [KEY_MAX_NUM-1:0] req,
        input int unsigned            last,
        input int unsigned            num
    );
        int unsigned idx;
        int unsigned pick;
        logic        found;
        pick  = last;
        found = 1'b0;
        for (int unsigned i = 1; i <= num; i++) begin
            idx = (last + i) % num;
            if (!found && req[idx[KEY_MAX_IDX_W-1:0]]) begin
                pick  = idx;
                found = 1'b1;
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/key_sync2.sv
// ---------------------------------------------------------------------------
// key_sync2
// WIDTH-bit two-flop synchronizer for raw key pins. Both stages reset to 1
// so that keys read as released until real samples have propagated.
// Ports:
//   clk    in   sampling clock
//   rst_n  in   asynchronous active-low reset
//   d      in   WIDTH asynchronous inputs
//   q      out  WIDTH synchronized outputs
// ---------------------------------------------------------------------------
module key_sync2 #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] stage1_d, stage1_q;
    logic [WIDTH-1:0] stage2_d, stage2_q;

    always_comb begin
        stage1_d = d;
        stage2_d = stage1_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stage1_q <= '1;
            stage2_q <= '1;
        end else begin
            stage1_q <= stage1_d;
            stage2_q <= stage2_d;
        end
    end

    assign q = stage2_q;

endmodule

// File: rtl/key_scan_ctrl.sv
// ---------------------------------------------------------------------------
// key_scan_ctrl
// Debounce scheduler for KEY_NUM active-low keys sharing one debounce
// counter. A round-robin FSM grants the counter to a key whose synchronized
// level differs from its committed level; the new level is committed only
// after it has held for CNT_MAX+1 cycles.
//
// Optional feature macro: KEY_RELEASE_EN
//   defined   : adds key_release, a one-cycle pulse when a key is released
//   undefined : releases update key_state silently
//
// Ports:
//   sys_clk     in   system clock, rising edge
//   sys_rst_n   in   asynchronous active-low reset
//   key_in      in   raw key pins, 0 = pressed, asynchronous
//   key_flag    out  one-cycle press pulse per key (registered)
//   key_state   out  committed debounced level per key, 1 = released
//   busy        out  high while the counter is owned (DEBOUNCE or COMMIT)
//   active_idx  out  index of the key owning the counter
//   key_release out  one-cycle release pulse (KEY_RELEASE_EN only)
// ---------------------------------------------------------------------------
module key_scan_ctrl
    import key_pkg::*;
#(
    parameter  int unsigned      KEY_NUM = 4,
    parameter  int unsigned      CNT_W   = KEY_CNT_W,
    // Must be below 2**CNT_W; cnt never counts past this value.
    parameter  logic [CNT_W-1:0] CNT_MAX = CNT_W'(KEY_CNT_MAX),
    localparam int unsigned      IDX_W   = (KEY_NUM > 1) ? $clog2(KEY_NUM) : 1
) (
    input  logic               sys_clk,
    input  logic               sys_rst_n,
    input  logic [KEY_NUM-1:0] key_in,
    output logic [KEY_NUM-1:0] key_flag,
    output logic [KEY_NUM-1:0] key_state,
    output logic               busy,
    output logic [IDX_W-1:0]   active_idx
`ifdef KEY_RELEASE_EN
    ,
    output logic [KEY_NUM-1:0] key_release
`endif
);

    logic [KEY_NUM-1:0]     key_sync;
    logic [KEY_NUM-1:0]     mismatch;
    logic [KEY_MAX_NUM-1:0] req_ext;

    key_fsm_e               state_d, state_q;
    logic [CNT_W-1:0]       cnt_d, cnt_q;
    logic [IDX_W-1:0]       active_idx_d, active_idx_q;
    logic [IDX_W-1:0]       last_grant_d, last_grant_q;
    logic [KEY_NUM-1:0]     key_state_d, key_state_q;
    logic [KEY_NUM-1:0]     key_flag_d, key_flag_q;
`ifdef KEY_RELEASE_EN
    logic [KEY_NUM-1:0]     key_release_d, key_release_q;
`endif

    logic                   owner_steady;
    logic                   cnt_done;

    key_sync2 #(
        .WIDTH (KEY_NUM)
    ) u_sync (
        .clk   (sys_clk),
        .rst_n (sys_rst_n),
        .d     (key_in),
        .q     (key_sync)
    );

    assign mismatch = key_sync ^ key_state_q;

    always_comb begin
        req_ext                = '0;
        req_ext[KEY_NUM-1:0]   = mismatch;
    end

    // Owner's synchronized level matches its committed level: it bounced back.
    assign owner_steady = (key_sync[active_idx_q] == key_state_q[active_idx_q]);
    assign cnt_done     = (cnt_q == CNT_MAX);

    // ---------------- state register ----------------
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            active_idx_q  <= '0;
            last_grant_q  <= IDX_W'(KEY_NUM - 1);
            key_state_q   <= '1;
            key_flag_q    <= '0;
`ifdef KEY_RELEASE_EN
            key_release_q <= '0;
`endif
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            active_idx_q  <= active_idx_d;
            last_grant_q  <= last_grant_d;
            key_state_q   <= key_state_d;
            key_flag_q    <= key_flag_d;
`ifdef KEY_RELEASE_EN
            key_release_q <= key_release_d;
`endif
        end
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (|mismatch) begin
                    state_d = DEBOUNCE;
                end
            end
            DEBOUNCE: begin
                if (owner_steady) begin
                    state_d = IDLE;
                end else if (cnt_done) begin
                    state_d = COMMIT;
                end
            end
            COMMIT: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // ---------------- output / datapath logic ----------------
    // The press/release pulse is registered on the DEBOUNCE->COMMIT edge so
    // it is high exactly during the COMMIT cycle; key_state flips one edge
    // later, when leaving COMMIT.
    always_comb begin
        cnt_d         = cnt_q;
        active_idx_d  = active_idx_q;
        last_grant_d  = last_grant_q;
        key_state_d   = key_state_q;
        key_flag_d    = '0;
`ifdef KEY_RELEASE_EN
        key_release_d = '0;
`endif
        busy          = (state_q != IDLE);

        unique case (state_q)
            IDLE: begin
                if (|mismatch) begin
                    active_idx_d = IDX_W'(rr_pick(req_ext, 32'(last_grant_q), KEY_NUM));
                    cnt_d        = '0;
                end
            end
            DEBOUNCE: begin
                if (owner_steady) begin
                    last_grant_d = active_idx_q;
                    cnt_d        = '0;
                end else if (cnt_done) begin
                    // New level is the inverse of the committed one.
                    if (key_state_q[active_idx_q]) begin
                        key_flag_d[active_idx_q] = 1'b1;
                    end
`ifdef KEY_RELEASE_EN
                    else begin
                        key_release_d[active_idx_q] = 1'b1;
                    end
`endif
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            COMMIT: begin
                key_state_d[active_idx_q] = ~key_state_q[active_idx_q];
                last_grant_d              = active_idx_q;
                cnt_d                     = '0;
            end
            default: begin
                cnt_d = '0;
            end
        endcase
    end

    assign key_flag    = key_flag_q;
    assign key_state   = key_state_q;
    assign active_idx  = active_idx_q;
`ifdef KEY_RELEASE_EN
    assign key_release = key_release_q;
`endif

endmodule

// File: tb/tb_key_scan_ctrl.sv
// ---------------------------------------------------------------------------
// tb_key_scan_ctrl
// Directed bench for key_scan_ctrl with KEY_NUM=4, CNT_MAX=4. Edge k is the
// first rising edge that samples a changed key_in; outputs are sampled 1 ns
// after each rising edge. Honours KEY_RELEASE_EN when defined.
// ---------------------------------------------------------------------------
module tb_key_scan_ctrl;

    localparam int unsigned KEY_NUM = 4;
    localparam int unsigned CNT_W   = 20;

    logic               sys_clk   = 1'b0;
    logic               sys_rst_n = 1'b0;
    logic [KEY_NUM-1:0] key_in    = 4'hF;
    logic [KEY_NUM-1:0] key_flag;
    logic [KEY_NUM-1:0] key_state;
    logic               busy;
    logic [1:0]         active_idx;
`ifdef KEY_RELEASE_EN
    logic [KEY_NUM-1:0] key_release;
`endif

    int n_err    = 0;
    int n_checks = 0;

    always #5 sys_clk = ~sys_clk;

    key_scan_ctrl #(
        .KEY_NUM (KEY_NUM),
        .CNT_W   (CNT_W),
        .CNT_MAX (20'd4)
    ) dut (
        .sys_clk     (sys_clk),
        .sys_rst_n   (sys_rst_n),
        .key_in      (key_in),
        .key_flag    (key_flag),
        .key_state   (key_state),
        .busy        (busy),
        .active_idx  (active_idx)
`ifdef KEY_RELEASE_EN
        ,
        .key_release (key_release)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic do_reset();
        sys_rst_n = 1'b0;
        key_in    = 4'hF;
        repeat (3) tick();
        sys_rst_n = 1'b1;
        tick();
    endtask

    // Single-key press or release served alone: grant at k+2, pulse at k+7,
    // key_state changes at k+8.
    task automatic run_single(input string name, input logic [3:0] flag_at7,
                              input logic [3:0] rel_at7, input logic [3:0] st_before,
                              input logic [3:0] st_after, input logic [1:0] idx);
        for (int e = 0; e <= 9; e++) begin
            tick();
            check($sformatf("%s_busy@%0d", name, e), 32'(busy), 32'((e >= 2 && e <= 7) ? 1 : 0));
            check($sformatf("%s_flag@%0d", name, e), 32'(key_flag), 32'((e == 7) ? flag_at7 : 4'h0));
            check($sformatf("%s_state@%0d", name, e), 32'(key_state), 32'((e >= 8) ? st_after : st_before));
            if (e == 2)
                check($sformatf("%s_idx", name), 32'(active_idx), 32'(idx));
`ifdef KEY_RELEASE_EN
            check($sformatf("%s_rel@%0d", name, e), 32'(key_release), 32'((e == 7) ? rel_at7 : 4'h0));
`else
            if (e == 7 && rel_at7 != 4'h0 && key_flag != 4'h0)
                check($sformatf("%s_relflag", name), 32'(key_flag), 32'h0);
`endif
        end
    endtask

    initial begin
        // ---- reset values ----
        do_reset();
        check("rst_state", 32'(key_state), 32'hF);
        check("rst_flag",  32'(key_flag),  32'h0);
        check("rst_busy",  32'(busy),      32'h0);
        check("rst_idx",   32'(active_idx), 32'h0);
        check("rst_cnt",   32'(dut.cnt_q), 32'h0);

        // ---- clean press of key 2 ----
        key_in[2] = 1'b0;
        run_single("press", 4'b0100, 4'b0000, 4'b1111, 4'b1011, 2'd2);

        // ---- bounce on key 0: low for 3 sampled cycles ----
        key_in[0] = 1'b0;
        for (int e = 0; e <= 9; e++) begin
            tick();
            check($sformatf("bounce_busy@%0d", e), 32'(busy), 32'((e >= 2 && e <= 4) ? 1 : 0));
            check($sformatf("bounce_flag@%0d", e), 32'(key_flag), 32'h0);
            check($sformatf("bounce_state@%0d", e), 32'(key_state), 32'hB);
            if (e == 2) begin
                check("bounce_idx", 32'(active_idx), 32'h0);
                key_in[0] = 1'b1;
            end
        end

        // ---- release of key 2 (last_grant=0, so key 2 is found from 1) ----
        key_in[2] = 1'b1;
        run_single("release", 4'b0000, 4'b0100, 4'b1011, 4'b1111, 2'd2);

        // ---- simultaneous press of keys 1 and 3 after reset ----
        do_reset();
        key_in = 4'b0101;
        for (int e = 0; e <= 16; e++) begin
            logic [3:0] fexp;
            logic [3:0] sexp;
            fexp = (e == 7) ? 4'b0010 : ((e == 14) ? 4'b1000 : 4'b0000);
            sexp = (e < 8) ? 4'b1111 : ((e < 15) ? 4'b1101 : 4'b0101);
            tick();
            check($sformatf("simul_flag@%0d", e), 32'(key_flag), 32'(fexp));
            check($sformatf("simul_busy@%0d", e), 32'(busy),
                  32'(((e >= 2 && e <= 7) || (e >= 9 && e <= 14)) ? 1 : 0));
            check($sformatf("simul_state@%0d", e), 32'(key_state), 32'(sexp));
            if (e == 2) check("simul_idx_first",  32'(active_idx), 32'h1);
            if (e == 9) check("simul_idx_second", 32'(active_idx), 32'h3);
        end

        // ---- reset asserted mid-debounce at cnt=2 ----
        do_reset();
        key_in = 4'b1101;
        for (int e = 0; e <= 4; e++) tick();
        check("midrst_cnt_before", 32'(dut.cnt_q), 32'h2);
        check("midrst_busy_before", 32'(busy), 32'h1);
        sys_rst_n = 1'b0;
        #1;
        check("midrst_busy",  32'(busy),        32'h0);
        check("midrst_flag",  32'(key_flag),    32'h0);
        check("midrst_cnt",   32'(dut.cnt_q),   32'h0);
        check("midrst_state", 32'(key_state),   32'hF);
        check("midrst_idx",   32'(active_idx),  32'h0);
        tick();
        tick();
        sys_rst_n = 1'b1;
        run_single("redeb", 4'b0010, 4'b0000, 4'b1111, 4'b1101, 2'd1);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
